keypad_opcode_decoder: RTL

- Parametrised successor of the 3-key opcode encoder: takes NUM_KEYS raw keypad lines and synchronises, debounces and edge-detects them.
- Each clean single-key press becomes exactly one opcode event, held in a one-entry output buffer with a valid/ready handshake.
- Sits between the keypad pins and the matrix-op controller, so the controller sees one event per press instead of a level that repeats for as long as the key is held.

---
 rtl/keypad_opcode_decoder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/keypad_opcode_decoder.sv
// rtl/keypad_opcode_decoder.sv - keypad synchroniser, debouncer and one-entry opcode event buffer
module keypad_opcode_decoder #(
    parameter int NUM_KEYS        = 3,
    parameter int OP_W            = 3,
    parameter int ENTER_KEY       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] in,
    input  logic                op_ready,
    input  logic                ovf_clr,
    output logic [OP_W-1:0]     opcode,
    output logic                op_valid,
    output logic                is_result,
    output logic                is_enter,
    output logic                multi_err,
    output logic                overflow
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [OP_W-1:0]  ENTER_OP = OP_W'(ENTER_KEY + 1);

    logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0] sync_d [SYNC_STAGES];
    logic [NUM_KEYS-1:0] sync_out;

    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] db_q, db_d;
    logic [NUM_KEYS-1:0] db_prev_q, db_prev_d;

    logic                strobe_q, strobe_d;
    logic [OP_W-1:0]     key_op_q, key_op_d;
    logic                multi_err_q, multi_err_d;

    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic                op_valid_q, op_valid_d;
    logic                overflow_q, overflow_d;

    logic                db_onehot;
    logic                db_rise;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain: raw lines enter stage 0, last stage feeds the debouncer
    always_comb begin
        sync_d[0] = in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Debounce: restart the count on any change, publish the candidate once it has been stable long enough
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sync_out != cand_q) begin
            cand_d = sync_out;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == CNT_MAX) begin
            db_d = cand_q;
        end
    end

    // Press detection: only a transition out of all-released counts; strobe and error are registered
    always_comb begin
        db_prev_d   = db_q;
        db_onehot   = (db_q != '0) && ((db_q & (db_q - NUM_KEYS'(1))) == '0);
        db_rise     = (db_prev_q == '0) && (db_q != '0);
        strobe_d    = db_rise && db_onehot;
        multi_err_d = db_rise && !db_onehot;
        key_op_d    = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (db_q[i]) begin
                key_op_d = OP_W'(i + 1);
            end
        end
    end

    // One-entry output buffer; a new overflow wins over a simultaneous clear
    always_comb begin
        opcode_d   = opcode_q;
        op_valid_d = op_valid_q;
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (strobe_q) begin
            if (!op_valid_q || op_ready) begin
                opcode_d   = key_op_q;
                op_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (op_valid_q && op_ready) begin
            opcode_d   = '0;
            op_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q      <= '0;
            cnt_q       <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            strobe_q    <= 1'b0;
            key_op_q    <= '0;
            multi_err_q <= 1'b0;
            opcode_q    <= '0;
            op_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            strobe_q    <= strobe_d;
            key_op_q    <= key_op_d;
            multi_err_q <= multi_err_d;
            opcode_q    <= opcode_d;
            op_valid_q  <= op_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign opcode    = opcode_q;
    assign op_valid  = op_valid_q;
    assign is_result = op_valid_q && (opcode_q != ENTER_OP);
    assign is_enter  = op_valid_q && (opcode_q == ENTER_OP);
    assign multi_err = multi_err_q;
    assign overflow  = overflow_q;

endmodule
